// File: rtl/tx_switch.sv
`default_nettype none
// ============================================================================
//  Module   : tx_switch
//  Purpose  : Merges the aw, ar, r, b and barrier request channels into a
//             single registered tx stream. Header beats are re-encoded with a
//             4-bit type in data[3:0]; aw/r bursts lock the grant until the
//             beat flagged "last" has been forwarded.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, reset            : clock, synchronous active-high reset
//    aw_din/last/valid/ready       : write header + payload burst
//    ar_din/valid/ready            : read request (single beat)
//    r_din/last/valid/ready        : read data header + payload burst
//    b_din/valid/ready             : write response (single beat)
//    barrier_din/valid/ready       : barrier (single beat)
//    tx_data/connection_id/last/valid/ready : merged output stream
// ----------------------------------------------------------------------------
//  Configuration
//    TX_SWITCH_RR_EN defined   : round-robin aw -> ar -> r -> b -> barrier,
//                                pointer advances on each accepted header.
//    TX_SWITCH_RR_EN undefined : fixed priority b > r > barrier > ar > aw.
// ============================================================================
module tx_switch (
   input  logic         clk,
   input  logic         reset,
   input  logic [127:0] aw_din,
   input  logic         aw_last,
   input  logic         aw_valid,
   output logic         aw_ready,
   input  logic [127:0] ar_din,
   input  logic         ar_valid,
   output logic         ar_ready,
   input  logic [127:0] r_din,
   input  logic         r_last,
   input  logic         r_valid,
   output logic         r_ready,
   input  logic [127:0] b_din,
   input  logic         b_valid,
   output logic         b_ready,
   input  logic [127:0] barrier_din,
   input  logic         barrier_valid,
   output logic         barrier_ready,
   output logic [127:0] tx_data,
   output logic [3:0]   tx_connection_id,
   output logic         tx_last,
   output logic         tx_valid,
   input  logic         tx_ready
);

   localparam logic [2:0] c_CH_AW  = 3'd0;
   localparam logic [2:0] c_CH_AR  = 3'd1;
   localparam logic [2:0] c_CH_R   = 3'd2;
   localparam logic [2:0] c_CH_B   = 3'd3;
   localparam logic [2:0] c_CH_BAR = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE     = 3'b001,
      S_AW_BURST = 3'b010,
      S_R_BURST  = 3'b100
   } state_t;

   state_t       r_state;
   state_t       w_state_nxt;

   logic [4:0]   w_valid_vec;
   logic [4:0]   w_grant;
   logic [4:0]   w_ready_vec;
   logic [2:0]   w_arb_idx;
   logic         w_arb_found;
   logic         w_advance;
   logic         w_accept;
   logic [127:0] w_beat_data;
   logic [3:0]   w_beat_id;
   logic         w_beat_last;
   logic [3:0]   r_burst_id;
   logic [127:0] r_tx_data;
   logic [3:0]   r_tx_id;
   logic         r_tx_last;
   logic         r_tx_valid;

   assign w_valid_vec = {barrier_valid, b_valid, r_valid, ar_valid, aw_valid};

   // Output register can take a new beat when empty or draining this cycle.
   assign w_advance = !reset && (!r_tx_valid || tx_ready);

`ifdef TX_SWITCH_RR_EN
   logic [2:0] r_rr_ptr;
   logic [3:0] w_rr_idx;

   // Scan the five channels starting at the pointer, wrapping modulo 5.
   always_comb begin
      w_arb_found = 1'b0;
      w_arb_idx   = c_CH_AW;
      w_rr_idx    = 4'd0;
      for (int k = 0; k < 5; k++) begin
         w_rr_idx = {1'b0, r_rr_ptr} + 4'(k);
         if (w_rr_idx >= 4'd5) w_rr_idx = w_rr_idx - 4'd5;
         if (!w_arb_found && w_valid_vec[w_rr_idx[2:0]]) begin
            w_arb_found = 1'b1;
            w_arb_idx   = w_rr_idx[2:0];
         end
      end
   end

   // Only headers (accepted in IDLE) move the pointer; payload beats do not.
   always_ff @(posedge clk) begin
      if (reset)
         r_rr_ptr <= c_CH_AW;
      else if (r_state == S_IDLE && w_accept)
         r_rr_ptr <= (w_arb_idx == c_CH_BAR) ? c_CH_AW : w_arb_idx + 3'd1;
   end
`else
   always_comb begin
      w_arb_found = |w_valid_vec;
      w_arb_idx   = c_CH_AW;
      if (b_valid)            w_arb_idx = c_CH_B;
      else if (r_valid)       w_arb_idx = c_CH_R;
      else if (barrier_valid) w_arb_idx = c_CH_BAR;
      else if (ar_valid)      w_arb_idx = c_CH_AR;
   end
`endif

   // During a burst the grant is pinned to the bursting channel.
   always_comb begin
      w_grant = 5'b0;
      case (r_state)
         S_AW_BURST: w_grant[c_CH_AW] = 1'b1;
         S_R_BURST:  w_grant[c_CH_R]  = 1'b1;
         default:    if (w_arb_found) w_grant[w_arb_idx] = 1'b1;
      endcase
   end

   assign w_ready_vec   = w_grant & {5{w_advance}};
   assign w_accept      = |(w_ready_vec & w_valid_vec);
   assign aw_ready      = w_ready_vec[c_CH_AW];
   assign ar_ready      = w_ready_vec[c_CH_AR];
   assign r_ready       = w_ready_vec[c_CH_R];
   assign b_ready       = w_ready_vec[c_CH_B];
   assign barrier_ready = w_ready_vec[c_CH_BAR];

   // Beat formatting: headers get their type nibble, payloads pass through.
   always_comb begin
      w_beat_data = 128'b0;
      w_beat_id   = 4'b0;
      w_beat_last = 1'b1;
      case (r_state)
         S_AW_BURST: begin
            w_beat_data = aw_din;
            w_beat_id   = r_burst_id;
            w_beat_last = aw_last;
         end
         S_R_BURST: begin
            w_beat_data = r_din;
            w_beat_id   = r_burst_id;
            w_beat_last = r_last;
         end
         default: begin
            case (w_arb_idx)
               c_CH_AW: begin
                  w_beat_data = {aw_din[127:4], 4'h1};
                  w_beat_id   = aw_din[3:0];
                  w_beat_last = aw_last;
               end
               c_CH_AR: begin
                  w_beat_data = {ar_din[127:4], 4'h2};
                  w_beat_id   = ar_din[3:0];
               end
               c_CH_R: begin
                  w_beat_data = {r_din[127:4], 4'h3};
                  w_beat_id   = r_din[3:0];
                  w_beat_last = r_last;
               end
               c_CH_B: begin
                  w_beat_data = {b_din[127:4], 4'h4};
                  w_beat_id   = b_din[3:0];
               end
               default: begin
                  // Barrier: bit 8 selects the type and is cleared on the wire.
                  w_beat_data = {barrier_din[127:9], 1'b0, barrier_din[7:4],
                                 (barrier_din[8] ? 4'h5 : 4'h6)};
                  w_beat_id   = barrier_din[3:0];
               end
            endcase
         end
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            // Only aw and r headers can carry last=0.
            if (w_accept && !w_beat_last) begin
               if (w_arb_idx == c_CH_AW)     w_state_nxt = S_AW_BURST;
               else if (w_arb_idx == c_CH_R) w_state_nxt = S_R_BURST;
            end
         end
         S_AW_BURST, S_R_BURST: begin
            if (w_accept && w_beat_last) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_burst_id <= 4'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_IDLE && w_accept) r_burst_id <= w_beat_id;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tx_data  <= 128'b0;
         r_tx_id    <= 4'b0;
         r_tx_last  <= 1'b0;
         r_tx_valid <= 1'b0;
      end else if (w_advance) begin
         if (w_accept) begin
            r_tx_data  <= w_beat_data;
            r_tx_id    <= w_beat_id;
            r_tx_last  <= w_beat_last;
            r_tx_valid <= 1'b1;
         end else begin
            r_tx_valid <= 1'b0;
         end
      end
   end

   assign tx_data          = r_tx_data;
   assign tx_connection_id = r_tx_id;
   assign tx_last          = r_tx_last;
   assign tx_valid         = r_tx_valid;

endmodule
`default_nettype wire

// File: tb/tb_tx_switch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tx_switch
//  Purpose  : Self-checking bench for tx_switch. A transaction-level
//             reference model runs every cycle alongside table vectors,
//             hand-written burst/backpressure sequences and random traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tx_switch;

   logic         clk = 1'b0;
   logic         reset;
   logic [127:0] aw_din, ar_din, r_din, b_din, barrier_din;
   logic         aw_last, aw_valid, aw_ready;
   logic         ar_valid, ar_ready;
   logic         r_last, r_valid, r_ready;
   logic         b_valid, b_ready;
   logic         barrier_valid, barrier_ready;
   logic [127:0] tx_data;
   logic [3:0]   tx_connection_id;
   logic         tx_last, tx_valid, tx_ready;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   tx_switch dut (
      .clk(clk), .reset(reset),
      .aw_din(aw_din), .aw_last(aw_last), .aw_valid(aw_valid), .aw_ready(aw_ready),
      .ar_din(ar_din), .ar_valid(ar_valid), .ar_ready(ar_ready),
      .r_din(r_din), .r_last(r_last), .r_valid(r_valid), .r_ready(r_ready),
      .b_din(b_din), .b_valid(b_valid), .b_ready(b_ready),
      .barrier_din(barrier_din), .barrier_valid(barrier_valid), .barrier_ready(barrier_ready),
      .tx_data(tx_data), .tx_connection_id(tx_connection_id), .tx_last(tx_last),
      .tx_valid(tx_valid), .tx_ready(tx_ready)
   );

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: channel index 0=aw 1=ar 2=r 3=b 4=barrier
   // ------------------------------------------------------------------
   int           m_burst = -1;
   logic [3:0]   m_bid   = 4'h0;
   int           m_ptr   = 0;
   logic         m_valid = 1'b0;
   logic         m_last  = 1'b0;
   logic [127:0] m_data  = '0;
   logic [3:0]   m_id    = 4'h0;
   bit           m_zero  = 1'b1;

   function automatic int pick(input logic [4:0] v, input int ptr);
`ifdef TX_SWITCH_RR_EN
      for (int k = 0; k < 5; k++)
         if (v[(ptr + k) % 5]) return (ptr + k) % 5;
      return -1;
`else
      int pri[5] = '{3, 2, 4, 1, 0};
      if (ptr < 0) return -1;
      foreach (pri[i])
         if (v[pri[i]]) return pri[i];
      return -1;
`endif
   endfunction

   always @(negedge clk) begin : model_blk
      logic [4:0]   vld, lst_v, exp_rdy, act_rdy;
      logic [127:0] din [5];
      logic [127:0] mask;
      logic [3:0]   ty;
      int           g;
      bit           avail;
      vld     = {barrier_valid, b_valid, r_valid, ar_valid, aw_valid};
      act_rdy = {barrier_ready, b_ready, r_ready, ar_ready, aw_ready};
      lst_v   = {1'b1, 1'b1, r_last, 1'b1, aw_last};
      din[0] = aw_din; din[1] = ar_din; din[2] = r_din; din[3] = b_din; din[4] = barrier_din;

      chk("model_tx_valid", {255'b0, tx_valid}, {255'b0, m_valid});
      if (m_valid || m_zero)
         chk("model_tx_beat", {123'b0, tx_last, tx_connection_id, tx_data},
             {123'b0, m_last, m_id, m_data});

      g = -1;
      avail = !m_valid || tx_ready;
      exp_rdy = 5'b0;
      if (!reset) begin
         g = (m_burst >= 0) ? m_burst : pick(vld, m_ptr);
         if (g >= 0 && avail) exp_rdy[g] = 1'b1;
      end
      chk("model_ready", {251'b0, act_rdy}, {251'b0, exp_rdy});

      if (reset) begin
         m_burst = -1; m_ptr = 0; m_valid = 1'b0; m_last = 1'b0;
         m_data = '0; m_id = 4'h0; m_zero = 1'b1;
      end else if (avail) begin
         if (g >= 0 && vld[g]) begin
            m_valid = 1'b1;
            m_zero  = 1'b0;
            m_last  = lst_v[g];
            if (m_burst >= 0) begin
               m_data = din[g];
               m_id   = m_bid;
               if (lst_v[g]) m_burst = -1;
            end else begin
               m_id = din[g][3:0];
               if (g == 4) begin
                  ty   = din[g][8] ? 4'h5 : 4'h6;
                  mask = 128'h10F;
               end else begin
                  ty   = 4'(g + 1);
                  mask = 128'hF;
               end
               m_data = (din[g] & ~mask) | {124'b0, ty};
               if (!lst_v[g]) begin
                  m_burst = g;
                  m_bid   = m_id;
               end
               m_ptr = (g + 1) % 5;
            end
         end else begin
            m_valid = 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers (inputs change only 1-2 time units after posedge)
   // ------------------------------------------------------------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      aw_valid = 0; ar_valid = 0; r_valid = 0; b_valid = 0; barrier_valid = 0;
   endtask

   task automatic drive(input int ch, input logic [127:0] d, input logic l);
      case (ch)
         0: begin aw_din = d; aw_last = l; aw_valid = 1; end
         1: begin ar_din = d; ar_valid = 1; end
         2: begin r_din = d; r_last = l; r_valid = 1; end
         3: begin b_din = d; b_valid = 1; end
         default: begin barrier_din = d; barrier_valid = 1; end
      endcase
   endtask

   function automatic logic [255:0] rdy_vec();
      return {251'b0, barrier_ready, b_ready, r_ready, ar_ready, aw_ready};
   endfunction

   function automatic logic [255:0] tx_beat();
      return {122'b0, tx_valid, tx_last, tx_connection_id, tx_data};
   endfunction

   function automatic logic [255:0] beat(input logic l, input logic [3:0] id, input logic [127:0] d);
      return {122'b0, 1'b1, l, id, d};
   endfunction

   typedef struct {
      int           ch;
      logic [127:0] din;
      logic         last;
      logic [127:0] exp_data;
      logic [3:0]   exp_id;
      logic         exp_last;
   } vec_t;

   vec_t         tbl [6];
   logic [127:0] pay [3];
   logic [255:0] held;
   logic [4:0]   rr_seq [6];

   initial begin
      reset = 1; tx_ready = 1;
      aw_din = '0; ar_din = '0; r_din = '0; b_din = '0; barrier_din = '0;
      aw_last = 0; r_last = 0;
      idle();
      repeat (3) cyc();

      // Reset state: readys stay low under reset even with every valid high.
      aw_valid = 1; ar_valid = 1; r_valid = 1; b_valid = 1; barrier_valid = 1;
      #1;
      chk("reset_readys", rdy_vec(), '0);
      chk("reset_tx", {122'b0, tx_valid, tx_last, tx_connection_id, tx_data}, '0);
      idle();
      reset = 0;
      cyc();

      // Single-beat vectors, one channel at a time.
      tbl[0] = '{0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3217, 1'b1,
                    128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3211, 4'h7, 1'b1};
      tbl[1] = '{1, 128'h1111_2222_3333_4444_5555_6666_7777_888C, 1'b0,
                    128'h1111_2222_3333_4444_5555_6666_7777_8882, 4'hC, 1'b1};
      tbl[2] = '{2, 128'hDEAD_BEEF_0000_0000_0000_0000_CAFE_F00D, 1'b1,
                    128'hDEAD_BEEF_0000_0000_0000_0000_CAFE_F003, 4'hD, 1'b1};
      tbl[3] = '{3, 128'h0000_0000_0000_0000_0000_0000_0000_00F5, 1'b0,
                    128'h0000_0000_0000_0000_0000_0000_0000_00F4, 4'h5, 1'b1};
      tbl[4] = '{4, 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_F1A2, 1'b0,
                    128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_F0A5, 4'h2, 1'b1};
      tbl[5] = '{4, 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_F2A2, 1'b0,
                    128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_F2A6, 4'h2, 1'b1};
      for (int i = 0; i < 6; i++) begin
         drive(tbl[i].ch, tbl[i].din, tbl[i].last);
         cyc();
         idle();
         chk($sformatf("vec%0d_beat", i), tx_beat(),
             beat(tbl[i].exp_last, tbl[i].exp_id, tbl[i].exp_data));
         cyc();
         chk($sformatf("vec%0d_drain", i), {255'b0, tx_valid}, '0);
      end

      // aw burst: header id 7 plus three payload beats.
      drive(0, 128'h0000_1111_2222_3333_4444_5555_6666_7707, 1'b0);
      cyc();
      chk("aw_hdr", tx_beat(), beat(1'b0, 4'h7, 128'h0000_1111_2222_3333_4444_5555_6666_7701));
      pay[0] = 128'hAAAA_0000_0000_0000_0000_0000_0000_0003;
      pay[1] = 128'hBBBB_0000_0000_0000_0000_0000_0000_000E;
      pay[2] = 128'hCCCC_0000_0000_0000_0000_0000_0000_0001;
      for (int k = 0; k < 3; k++) begin
         drive(0, pay[k], k == 2);
         cyc();
         chk($sformatf("aw_pay%0d", k), tx_beat(), beat(k == 2, 4'h7, pay[k]));
      end
      idle();
      cyc();

      // r burst of 4 with b waiting from beat 2: b locked out until r last.
      drive(2, 128'h5555_0000_0000_0000_0000_0000_0000_0009, 1'b0);
      cyc();
      for (int k = 1; k < 4; k++) begin
         drive(2, {32'(k), 96'h0}, k == 3);
         drive(3, 128'h0000_0000_0000_0000_0000_0000_0000_0036, 1'b0);
         #1;
         chk($sformatf("r_burst_readys%0d", k), rdy_vec(), 256'b00100);
         cyc();
         chk($sformatf("r_burst_beat%0d", k), tx_beat(), beat(k == 3, 4'h9, {32'(k), 96'h0}));
      end
      r_valid = 0;
      #1;
      chk("b_after_r", rdy_vec(), 256'b01000);
      cyc();
      idle();
      chk("b_beat", tx_beat(), beat(1'b1, 4'h6, 128'h0000_0000_0000_0000_0000_0000_0000_0034));
      cyc();

      // Backpressure: ar beat held while tx_ready=0 for five cycles.
      tx_ready = 0;
      drive(1, 128'h0A0A_0000_0000_0000_0000_0000_0000_0013, 1'b0);
      cyc();
      held = beat(1'b1, 4'h3, 128'h0A0A_0000_0000_0000_0000_0000_0000_0012);
      drive(1, 128'h0B0B_0000_0000_0000_0000_0000_0000_0024, 1'b0);
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("stall_readys%0d", k), rdy_vec(), '0);
         chk($sformatf("stall_tx%0d", k), tx_beat(), held);
         cyc();
      end
      tx_ready = 1;
      #1;
      chk("stall_release_ready", rdy_vec(), 256'b00010);
      cyc();
      idle();
      chk("stall_next_beat", tx_beat(), beat(1'b1, 4'h4, 128'h0B0B_0000_0000_0000_0000_0000_0000_0022));
      cyc();

      // All five valid continuously after a fresh reset.
      reset = 1;
      cyc();
      reset = 0;
      drive(0, 128'h1, 1'b1); drive(1, 128'h2, 1'b1); drive(2, 128'h3, 1'b1);
      drive(3, 128'h4, 1'b1); drive(4, 128'h105, 1'b1);
`ifdef TX_SWITCH_RR_EN
      rr_seq = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
`else
      rr_seq = '{5'b01000, 5'b01000, 5'b01000, 5'b01000, 5'b01000, 5'b01000};
`endif
      for (int k = 0; k < 6; k++) begin
         #1;
         chk($sformatf("arb_grant%0d", k), rdy_vec(), {251'b0, rr_seq[k]});
         cyc();
      end
      idle();
      cyc();

      // Reset in the middle of an aw burst.
      drive(0, 128'h0000_0000_0000_0000_0000_0000_0000_00B8, 1'b0);
      cyc();
      drive(0, 128'h0000_0000_0000_0000_0000_0000_0000_0777, 1'b0);
      cyc();
      reset = 1;
      cyc();
      chk("reset_mid_burst_valid", {255'b0, tx_valid}, '0);
      reset = 0;
      idle();
      drive(2, 128'h0000_0000_0000_0000_0000_0000_0000_004A, 1'b1);
      #1;
      chk("after_reset_idle_grant", rdy_vec(), 256'b00100);
      cyc();
      idle();
      chk("after_reset_beat", tx_beat(), beat(1'b1, 4'hA, 128'h0000_0000_0000_0000_0000_0000_0000_0043));
      cyc();

      // Random traffic checked by the model every cycle.
      for (int n = 0; n < 600; n++) begin
         aw_din = {$urandom, $urandom, $urandom, $urandom};
         ar_din = {$urandom, $urandom, $urandom, $urandom};
         r_din = {$urandom, $urandom, $urandom, $urandom};
         b_din = {$urandom, $urandom, $urandom, $urandom};
         barrier_din = {$urandom, $urandom, $urandom, $urandom};
         aw_valid = ($urandom_range(0, 1) == 1);
         ar_valid = ($urandom_range(0, 2) == 0);
         r_valid = ($urandom_range(0, 1) == 1);
         b_valid = ($urandom_range(0, 2) == 0);
         barrier_valid = ($urandom_range(0, 2) == 0);
         aw_last = ($urandom_range(0, 2) == 0);
         r_last = ($urandom_range(0, 2) == 0);
         tx_ready = ($urandom_range(0, 9) < 7);
         reset = ($urandom_range(0, 99) == 0);
         cyc();
      end
      reset = 0;
      idle();
      tx_ready = 1;
      repeat (3) cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tx_switch.md
TX_SWITCH -- requirements
Module: tx_switch

Interface
REQ-001 SHALL have ports: clk  input  1  clock; reset  input  1  synchronous, active-high reset.
REQ-002 SHALL have ports: aw_din  input  128  write header/payload, header [3:0]=connection id; aw_last  input  1; aw_valid  input  1; aw_ready  output  1.
REQ-003 SHALL have ports: ar_din  input  128; ar_valid  input  1; ar_ready  output  1 (single beat).
REQ-004 SHALL have ports: r_din  input  128; r_last  input  1; r_valid  input  1; r_ready  output  1.
REQ-005 SHALL have ports: b_din  input  128; b_valid  input  1; b_ready  output  1 (single beat).
REQ-006 SHALL have ports: barrier_din  input  128; barrier_valid  input  1; barrier_ready  output  1 (single beat).
REQ-007 SHALL have ports: tx_data  output  128; tx_connection_id  output  4; tx_last  output  1; tx_valid  output  1; tx_ready  input  1.
REQ-008 SHALL treat reset as reset, synchronous, active-high, on clock clk.

Function
REQ-009 SHALL merge five channels into one tx stream via a registered output stage; latency input handshake -> tx_valid = 1 cycle.
REQ-010 SHALL assert a channel's ready only when that channel is granted, reset=0, and (tx_valid=0 or tx_ready=1); at most one ready high per cycle.
REQ-011 SHALL hold tx_data/tx_connection_id/tx_last/tx_valid stable while tx_valid=1 and tx_ready=0; clear tx_valid on tx_ready=1 with no new beat.
REQ-012 Header encoding, tx_connection_id = din[3:0]: aw -> tx_data={din[127:4],4'h1}; ar -> 4'h2; r -> 4'h3; b -> 4'h4.
REQ-013 Barrier header SHALL encode tx_data={din[127:9],1'b0,din[7:4],type}, type=4'h5 if din[8]=1 else 4'h6.
REQ-014 ar, b, barrier beats SHALL drive tx_last=1; aw/r header drives tx_last=aw_last/r_last.
REQ-015 FSM states IDLE, AW_BURST, R_BURST (one-hot); reset -> IDLE.
REQ-016 IDLE: arbitrate among valid channels; accepted aw header with aw_last=0 -> AW_BURST; accepted r header with r_last=0 -> R_BURST; otherwise remain IDLE.
REQ-017 AW_BURST/R_BURST: grant locked to that channel; payload beats forwarded unmodified, tx_last=din last; tx_connection_id held at the header's id; accepted beat with last=1 -> IDLE.
REQ-018 Other channels' valid SHALL be ignored (ready=0) during a burst; no interleaving.
REQ-019 No valid inputs in IDLE: no grant, state unchanged, tx_valid drops after current beat drains.

Reset
REQ-020 On reset: tx_valid=0, tx_last=0, tx_data=0, tx_connection_id=0, all channel readys=0, state=IDLE, arbitration pointer=aw.
REQ-021 Reset mid-burst SHALL abandon the burst and discard the registered beat; next header after reset is arbitrated fresh.

Configuration
REQ-022 Macro TX_SWITCH_RR_EN defined: round-robin, order aw,ar,r,b,barrier; pointer moves to channel after the granted one on each accepted header, not on payload beats.
REQ-023 Macro TX_SWITCH_RR_EN undefined: fixed priority b > r > barrier > ar > aw; no pointer register.

Verification
REQ-024 aw header din[3:0]=4'h7, aw_last=0, then 3 payload beats, last on 3rd -> 4 tx beats, first [3:0]=4'h1, conn id 7 on all, tx_last only on 4th.
REQ-025 barrier_din[8]=1, [7:4]=4'hA, [3:0]=4'h2 -> tx_data[3:0]=4'h5, [8]=0, [7:4]=4'hA, conn id 2, tx_last=1; with [8]=0 -> type 4'h6.
REQ-026 r burst of 4 beats in progress, b_valid asserted at beat 2 -> b_ready=0 until r last accepted, then b beat sent next.
REQ-027 tx_ready=0 for 5 cycles with ar beat pending -> tx outputs stable, all readys 0; tx_ready=1 -> beat accepted, next beat follows 1 cycle later.
REQ-028 With TX_SWITCH_RR_EN, all five valid continuously -> grant order aw,ar,r,b,barrier,aw; without it -> b repeatedly granted, aw starved; reset asserted mid aw burst -> tx_valid=0 next cycle, state IDLE.
